// File: rtl/frame_read_timing_gen.sv
// frame_read_timing_gen
// Produces raster timing (sync, back porch, active, front porch for both
// lines and frames) and fetches pixels from a 1-cycle-latency frame memory.
// The sync/DE outputs are delayed one clock so they line up with the RAM data.
//
// Ports:
//   clk, rst        pixel clock (rising edge), async active-high reset
//   i_en            level-sensitive run request; frames always finish whole
//   o_rd_en         frame-memory read strobe
//   o_rd_addr       frame-memory read address (pixel index y*HRES+x)
//   i_rd_data       RAM read data, valid one clock after o_rd_en
//   o_vsync/o_hsync active-high syncs (stage 1)
//   o_de            data enable (stage 1), coincides with i_rd_data
//   o_data          pixel data, zero when o_de is low
//   o_frame_done    one-clock pulse aligned with the frame's last position
//   o_busy          high while the raster is not idle
module frame_read_timing_gen #(
  parameter int DATA_WIDTH = 24,
  parameter int HRES       = 320,
  parameter int VRES       = 240,
  parameter int HSW        = 4,
  parameter int HBP        = 8,
  parameter int HFP        = 8,
  parameter int VSW        = 2,
  parameter int VBP        = 4,
  parameter int VFP        = 4,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_vsync,
  output logic                  o_hsync,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int HTOTAL = HSW + HBP + HRES + HFP;
  localparam int VTOTAL = VSW + VBP + VRES + VFP;
  localparam int HCW    = $clog2(HTOTAL);
  localparam int VCW    = $clog2(VTOTAL);

  localparam logic [HCW-1:0] H_LAST      = HCW'(HTOTAL - 1);
  localparam logic [HCW-1:0] H_SYNC_END  = HCW'(HSW);
  localparam logic [HCW-1:0] H_ACT_FIRST = HCW'(HSW + HBP);
  localparam logic [HCW-1:0] H_ACT_LAST  = HCW'(HSW + HBP + HRES - 1);
  localparam logic [VCW-1:0] V_LAST      = VCW'(VTOTAL - 1);
  localparam logic [VCW-1:0] V_SYNC_END  = VCW'(VSW);
  localparam logic [VCW-1:0] V_ACT_FIRST = VCW'(VSW + VBP);
  localparam logic [VCW-1:0] V_ACT_LAST  = VCW'(VSW + VBP + VRES - 1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(HRES * VRES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [HCW-1:0]        h_cnt_q, h_cnt_d;
  logic [VCW-1:0]        v_cnt_q, v_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic                  vs_q, vs_d;
  logic                  hs_q, hs_d;
  logic                  de_q, de_d;
  logic                  done_q, done_d;

  logic running;
  logic last_pos;

  function automatic logic in_active(input logic [HCW-1:0] h, input logic [VCW-1:0] v);
    return (v >= V_ACT_FIRST) && (v <= V_ACT_LAST) &&
           (h >= H_ACT_FIRST) && (h <= H_ACT_LAST);
  endfunction

  always_comb begin
    running  = (state_q != ST_IDLE);
    last_pos = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    // FSM: frame boundaries are the only exit points from the raster.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_en) state_d = ST_RUN;
      ST_RUN: begin
        if (last_pos)   state_d = i_en ? ST_RUN : ST_IDLE;
        else if (!i_en) state_d = ST_STOP;
      end
      ST_STOP: if (last_pos) state_d = i_en ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Counters sit at 0 in IDLE and wrap to 0 at the end of every frame.
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (running && !last_pos) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = v_cnt_q + VCW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HCW'(1);
        v_cnt_d = v_cnt_q;
      end
    end

    // Read strobe is computed from the next counter values so the registered
    // strobe lines up with the counter state it describes.
    rd_en_d = (state_d != ST_IDLE) && in_active(h_cnt_d, v_cnt_d);

    rd_addr_d = rd_addr_q;
    if ((state_d == ST_IDLE) || ((h_cnt_d == '0) && (v_cnt_d == '0)))
      rd_addr_d = '0;
    else if (rd_en_q)
      rd_addr_d = (rd_addr_q == A_LAST) ? '0 : rd_addr_q + ADDR_WIDTH'(1);

    // Stage 1: one clock behind the read strobe; zeros once IDLE is reached.
    vs_d   = running && (v_cnt_q < V_SYNC_END);
    hs_d   = running && (h_cnt_q < H_SYNC_END);
    de_d   = rd_en_q;
    done_d = running && last_pos;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      de_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      vs_q      <= vs_d;
      hs_q      <= hs_d;
      de_q      <= de_d;
      done_q    <= done_d;
    end
  end

  assign o_rd_en      = rd_en_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_vsync      = vs_q;
  assign o_hsync      = hs_q;
  assign o_de         = de_q;
  assign o_data       = de_q ? i_rd_data : '0;
  assign o_frame_done = done_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_read_timing_gen.sv
// Bench for frame_read_timing_gen using a reduced raster (8x4 active,
// 15x8 total, 120 clocks per frame). Stimulus pushes expected pixel and edge
// events (with their cycle numbers) into queues; a monitor pops and compares.
module tb_frame_read_timing_gen;

  localparam int DW = 24;
  localparam int AW = 5;
  localparam int HRES = 8, VRES = 4;
  localparam int HSW = 2, HBP = 3, HFP = 2;
  localparam int VSW = 1, VBP = 2, VFP = 1;
  localparam int HT = HSW + HBP + HRES + HFP;   // 15
  localparam int VT = VSW + VBP + VRES + VFP;   // 8
  localparam int FRAME = HT * VT;               // 120

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_en = 1'b0;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rd_data = '0;
  logic          o_vsync, o_hsync, o_de, o_frame_done, o_busy;
  logic [DW-1:0] o_data;

  frame_read_timing_gen #(
    .DATA_WIDTH(DW), .HRES(HRES), .VRES(VRES),
    .HSW(HSW), .HBP(HBP), .HFP(HFP),
    .VSW(VSW), .VBP(VBP), .VFP(VFP),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .i_en(i_en),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de), .o_data(o_data),
    .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  function automatic logic [DW-1:0] ram_word(input int a);
    return 24'hC30000 | (24'(a & 31) << 8) | 24'(8'hFF ^ 8'(a));
  endfunction

  // Synchronous RAM model; garbage when not reading exposes o_data gating.
  always @(posedge clk) i_rd_data <= o_rd_en ? ram_word(int'(o_rd_addr)) : 24'h0BAD00;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } pix_t;

  pix_t  pix_q[$];
  int    evq[5][$];
  string ev_name[5] = '{"vs_rise", "vs_fall", "hs_rise", "hs_fall", "done"};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s unexpected event at cycle %0d", name, cyc);
  endtask

  // Expected events for a frame whose first counter cycle (0,0) is s.
  task automatic push_frame(input int s);
    pix_t p;
    evq[0].push_back(s + 1);
    evq[1].push_back(s + 1 + VSW * HT);
    for (int l = 0; l < VT; l++) begin
      evq[2].push_back(s + l * HT + 1);
      evq[3].push_back(s + l * HT + 1 + HSW);
    end
    evq[4].push_back(s + FRAME);
    for (int i = 0; i < HRES * VRES; i++) begin
      p.cyc  = s + (VSW + VBP + i / HRES) * HT + HSW + HBP + (i % HRES) + 1;
      p.data = ram_word(i);
      pix_q.push_back(p);
    end
  endtask

  task automatic flush_all();
    pix_q.delete();
    for (int k = 0; k < 5; k++) evq[k].delete();
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_pix_left"}, pix_q.size(), 0);
    for (int k = 0; k < 5; k++) chk({tag, "_", ev_name[k], "_left"}, evq[k].size(), 0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor
  logic vs_p = 1'b0, hs_p = 1'b0, dn_p = 1'b0;
  always @(negedge clk) begin
    logic [4:0] ev;
    pix_t p;
    if (rst) begin
      chk("rst_outputs", {o_vsync, o_hsync, o_de, o_rd_en, o_frame_done, o_busy, o_data}, 0);
      vs_p = 1'b0; hs_p = 1'b0; dn_p = 1'b0;
    end else begin
      if (o_de) begin
        if (pix_q.size() == 0) unexpected("pixel");
        else begin
          p = pix_q.pop_front();
          chk("pix_cycle", cyc, p.cyc);
          chk("pix_data", o_data, p.data);
        end
      end else begin
        chk("data_gate", o_data, 0);
      end
      ev = {o_frame_done & ~dn_p, ~o_hsync & hs_p, o_hsync & ~hs_p, ~o_vsync & vs_p, o_vsync & ~vs_p};
      for (int k = 0; k < 5; k++) begin
        if (ev[k]) begin
          if (evq[k].size() == 0) unexpected(ev_name[k]);
          else chk(ev_name[k], cyc, evq[k].pop_front());
        end
      end
      vs_p = o_vsync; hs_p = o_hsync; dn_p = o_frame_done;
    end
  end

  int s;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Idle after reset with i_en low.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_busy", o_busy, 0);
      chk("idle_rd_en", o_rd_en, 0);
      chk("idle_sync", {o_vsync, o_hsync, o_de}, 0);
    end

    // Frame A: i_en toggles mid-frame, low on the last clock -> single frame.
    i_en = 1'b1;
    s = cyc + 1;
    push_frame(s);
    wait_cyc(s + 40);  i_en = 1'b0;
    wait_cyc(s + 60);  i_en = 1'b1;
    wait_cyc(s + 80);  i_en = 1'b0;
    wait_cyc(s + 119); chk("a_busy_last", o_busy, 1);
    wait_cyc(s + 120); chk("a_busy_idle", o_busy, 0);
    wait_cyc(s + 160);
    chk("a_rd_en_after", o_rd_en, 0);
    check_drained("a");

    // Frames B and C back to back; reset in the middle of C.
    i_en = 1'b1;
    s = cyc + 1;
    push_frame(s);
    push_frame(s + FRAME);
    wait_cyc(s + 119); chk("b_busy_last", o_busy, 1);
    wait_cyc(s + 180);
    chk("c_pix_pending", pix_q.size(), 24);
    chk("c_done_pending", evq[4].size(), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_out", {o_vsync, o_hsync, o_de, o_rd_en, o_frame_done, o_busy}, 0);
    chk("rst_async_addr", o_rd_addr, 0);
    i_en = 1'b0;
    flush_all();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", o_busy, 0);

    // Frame D: i_en dropped exactly on the last clock of a RUN frame.
    i_en = 1'b1;
    s = cyc + 1;
    push_frame(s);
    wait_cyc(s + 119);
    chk("d_busy_last", o_busy, 1);
    i_en = 1'b0;
    wait_cyc(s + 121); chk("d_busy_idle", o_busy, 0);
    wait_cyc(s + 160);
    chk("d_rd_en_after", o_rd_en, 0);
    check_drained("d");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_read_timing_gen.md
Name: frame_read_timing_gen

Overview:
- Upstream stage of the PPM file write model, driving its vsync/hsync/de/data stream.
- Generates raster timing and reads pixels from the frame memory.
- The read path is a synchronous RAM with 1-cycle latency.
- Delays the sync and DE outputs by one cycle so `o_de` coincides with the RAM read data.
- Runs frame after frame while enabled; always stops on a frame boundary.

Parameters:
- DATA_WIDTH, 24, pixel width (RGB888: R=[23:16], G=[15:8], B=[7:0]).
- HRES, 320, active pixels per line.
- VRES, 240, active lines per frame.
- HSW, 4, hsync width in clocks.
- HBP, 8, horizontal back porch in clocks.
- HFP, 8, horizontal front porch in clocks.
- VSW, 2, vsync width in lines.
- VBP, 4, vertical back porch in lines.
- VFP, 4, vertical front porch in lines.
- ADDR_WIDTH, 17, frame-memory address width; must satisfy 2^ADDR_WIDTH >= HRES*VRES.

Ports:
- clk  in  1  pixel clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_en  in  1  run request, level-sensitive.
- o_rd_en  out  1  frame-memory read strobe.
- o_rd_addr  out  ADDR_WIDTH  frame-memory read address.
- i_rd_data  in  DATA_WIDTH  RAM data, valid 1 clk after o_rd_en.
- o_vsync  out  1  vertical sync, active-high.
- o_hsync  out  1  horizontal sync, active-high.
- o_de  out  1  data enable, active-high.
- o_data  out  DATA_WIDTH  pixel data; 0 when o_de=0.
- o_frame_done  out  1  1-clk pulse on the last clock of each frame.
- o_busy  out  1  high while state != IDLE.

Behaviour:
- Reset (async, immediate, including mid-frame): state=IDLE, counters=0, all outputs 0.
- Line and frame lengths:
  - HTOTAL = HSW+HBP+HRES+HFP (default 340).
  - VTOTAL = VSW+VBP+VRES+VFP (default 250).
  - Frame length 85000 clks.
- Counters:
  - h_cnt runs 0..HTOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; runs 0..VTOTAL-1 and wraps to 0.
- Line segment order: sync, back porch, active, front porch. Frame segment order is the same, in lines.
- Stage 0 (combinational from counters):
  - vs0 = (v_cnt < VSW).
  - hs0 = (h_cnt < HSW), on every line including vsync and porch lines.
  - act0 = (VSW+VBP <= v_cnt < VSW+VBP+VRES) && (HSW+HBP <= h_cnt < HSW+HBP+HRES).
- Read path:
  - o_rd_en = act0, registered so that it asserts in the same clock as the counter state.
  - o_rd_addr = pixel index y*HRES+x, kept as an incrementing register.
  - The address increments after each read; it is held between lines.
  - It returns to 0 at frame start (v_cnt=0, h_cnt=0). Range 0..HRES*VRES-1 (default 76799); it never exceeds this.
- Stage 1 (registered):
  - o_vsync, o_hsync and o_de are vs0, hs0 and act0 delayed exactly 1 clk relative to o_rd_en.
  - o_data = i_rd_data when o_de, else 0.
- FSM:
  - IDLE: counters held at 0, no reads. Go to RUN when i_en=1; the first frame starts in the next clock with h_cnt=v_cnt=0.
  - RUN: raster active. If i_en=0 at any cycle, go to STOP; the current frame continues.
  - STOP: raster continues to the end of the frame. On the last clock (v_cnt=VTOTAL-1, h_cnt=HTOTAL-1):
    - return to IDLE if i_en=0;
    - otherwise go to RUN with no gap.
  - The i_en=1 check also applies on the last clock in RUN: the next frame starts immediately.
- o_frame_done: asserted on the stage-1 clock that carries the last pixel position of the frame, i.e. aligned with the stage-1 outputs.
- Stage-1 flush on entering IDLE: stage-1 registers clear on the next clock, so o_vsync/o_hsync/o_de return to 0.
- An i_en toggle within one frame never truncates or extends that frame.
- Framing seen by the downstream consumer:
  - o_vsync falls after VSW lines, which marks frame start.
  - o_vsync rises at the next frame's start, which marks frame end.
  - Every frame delivers exactly HRES*VRES o_de cycles.

Test Plan:
- Reset with i_en=0, then hold → all outputs 0, o_busy=0 for 1000 clks.
- i_en=1 at cycle T; frame start is T+1. Defaults give:
  - o_vsync high during T+2..T+681;
  - first o_rd_en at T+1+2052 with addr=0;
  - first o_de at T+1+2053;
  - o_data equals RAM content of addr 0.
- Run one full frame with RAM[a]=a → exactly 76800 o_de cycles; data 0..76799 in order.
- Check every line → each line has 320 consecutive o_de clocks; o_hsync is 4 clks wide every 340 clks; last o_rd_addr is 76799, then 0 in the next frame.
- i_en low mid-frame 1 → frame completes with 76800 pixels; o_frame_done pulses once; then IDLE, o_busy=0, no further o_rd_en.
- i_en held high for 2 frames → second frame begins with no gap (85000-clk period); assert rst mid-frame 2 → outputs 0 in the same cycle, restart from addr 0 after deassertion.
